// File: rtl/cfu_cmd_pkg.sv
// Shared opcodes, FSM state type, cfg register indices and C-slice helper
// for the CFU command engine.
package cfu_cmd_pkg;

    localparam logic [6:0] OP_SRST    = 7'd1;
    localparam logic [6:0] OP_CFG_WR  = 7'd2;
    localparam logic [6:0] OP_CFG_RD  = 7'd3;
    localparam logic [6:0] OP_WR_A    = 7'd8;
    localparam logic [6:0] OP_RD_A    = 7'd9;
    localparam logic [6:0] OP_WR_B    = 7'd10;
    localparam logic [6:0] OP_RD_B    = 7'd11;
    localparam logic [6:0] OP_START   = 7'd12;
    localparam logic [6:0] OP_BUSY    = 7'd13;
    localparam logic [6:0] OP_RD_C    = 7'd14;
    localparam logic [6:0] OP_SET_PTR = 7'd19;
    localparam logic [6:0] OP_AUTO_A  = 7'd20;
    localparam logic [6:0] OP_AUTO_B  = 7'd21;
    localparam logic [6:0] OP_LAST    = 7'd22;
    localparam logic [6:0] OP_ERR     = 7'd23;

    localparam logic [1:0] CFG_K      = 2'd0;
    localparam logic [1:0] CFG_M      = 2'd1;
    localparam logic [1:0] CFG_N      = 2'd2;
    localparam logic [1:0] CFG_OFFSET = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_RUN     = 3'd3,
        ST_RESP    = 3'd4
    } state_e;

    function automatic int slices_of(input int c_bits);
        return c_bits / 32;
    endfunction

endpackage

// File: rtl/cfu_c_slice_sel.sv
// Picks one 32-bit slice out of a C buffer word; the slice number wraps
// modulo the number of slices in the word.
module cfu_c_slice_sel
    import cfu_cmd_pkg::*;
#(
    parameter int C_BITS = 128
) (
    input  logic [C_BITS-1:0] c_word_i,
    input  logic [31:0]       slice_i,
    output logic [31:0]       data_o
);

    localparam int SLICES = slices_of(C_BITS);

    logic [31:0] idx_s;

    assign idx_s = slice_i % 32'(SLICES);

    // Slice multiplexer
    always_comb begin
        data_o = 32'h0;
        for (int i = 0; i < SLICES; i++) begin
            data_o = (idx_s == 32'(i)) ? c_word_i[32*i +: 32] : data_o;
        end
    end

endmodule

// File: rtl/cfu_cmd_engine.sv
// CFU command/response front-end: decodes custom-instruction commands, owns the
// cfg registers, drives the host side of the A/B/C buffers and launches the TPU.
module cfu_cmd_engine
    import cfu_cmd_pkg::*;
#(
    parameter int ADDR_BITS = 12,
    parameter int C_BITS    = 128,
    parameter int CNT_BITS  = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [9:0]           cmd_payload_function_id,
    input  logic [31:0]          cmd_payload_inputs_0,
    input  logic [31:0]          cmd_payload_inputs_1,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_payload_outputs_0,
    output logic                 a_wr_en,
    output logic                 b_wr_en,
    output logic [ADDR_BITS-1:0] a_index,
    output logic [ADDR_BITS-1:0] b_index,
    output logic [ADDR_BITS-1:0] c_index,
    output logic [31:0]          a_wdata,
    output logic [31:0]          b_wdata,
    input  logic [31:0]          a_rdata,
    input  logic [31:0]          b_rdata,
    input  logic [C_BITS-1:0]    c_rdata,
    output logic                 host_owns,
    output logic                 tpu_start,
    input  logic                 tpu_busy,
    output logic [31:0]          cfg_k,
    output logic [31:0]          cfg_m,
    output logic [31:0]          cfg_n,
    output logic [31:0]          cfg_offset
);

    state_e                 state_q;
    logic [6:0]             op_q;
    logic [6:0]             op_s;
    logic                   rsp_valid_q;
    logic [31:0]            rsp_payload_q;
    logic                   a_wr_en_q, b_wr_en_q;
    logic [ADDR_BITS-1:0]   a_index_q, b_index_q, c_index_q;
    logic [31:0]            a_wdata_q, b_wdata_q;
    logic                   host_owns_q, tpu_start_q;
    logic [3:0][31:0]       cfg_q;
    logic [ADDR_BITS-1:0]   ptr_a_q, ptr_b_q;
    logic [CNT_BITS-1:0]    cnt_q, last_cnt_q, cnt_d;
    logic                   err_q;
    logic [31:0]            c_slice_q;
    logic [31:0]            c_slice_data_s;
    logic                   unused_func_bits_s;

    assign op_s               = cmd_payload_function_id[9:3];
    assign unused_func_bits_s = ^cmd_payload_function_id[2:0];
    assign cnt_d              = (cnt_q == {CNT_BITS{1'b1}}) ? cnt_q : cnt_q + CNT_BITS'(1);

    cfu_c_slice_sel #(
        .C_BITS (C_BITS)
    ) u_c_slice_sel (
        .c_word_i (c_rdata),
        .slice_i  (c_slice_q),
        .data_o   (c_slice_data_s)
    );

    // Command FSM with its registered outputs, cfg, pointers and run counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            op_q          <= 7'd0;
            rsp_valid_q   <= 1'b0;
            rsp_payload_q <= 32'h0;
            a_wr_en_q     <= 1'b0;
            b_wr_en_q     <= 1'b0;
            a_index_q     <= '0;
            b_index_q     <= '0;
            c_index_q     <= '0;
            a_wdata_q     <= 32'h0;
            b_wdata_q     <= 32'h0;
            host_owns_q   <= 1'b1;
            tpu_start_q   <= 1'b0;
            cfg_q         <= '0;
            ptr_a_q       <= '0;
            ptr_b_q       <= '0;
            cnt_q         <= '0;
            last_cnt_q    <= '0;
            err_q         <= 1'b0;
            c_slice_q     <= 32'h0;
        end else begin
            a_wr_en_q   <= 1'b0;
            b_wr_en_q   <= 1'b0;
            tpu_start_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op_q          <= op_s;
                        rsp_valid_q   <= 1'b1;
                        rsp_payload_q <= 32'h0;
                        state_q       <= ST_RESP;
                        case (op_s)
                            OP_SRST: begin
                                cfg_q      <= '0;
                                ptr_a_q    <= '0;
                                ptr_b_q    <= '0;
                                cnt_q      <= '0;
                                last_cnt_q <= '0;
                                err_q      <= 1'b0;
                            end
                            OP_CFG_WR: cfg_q[cmd_payload_inputs_0[1:0]] <= cmd_payload_inputs_1;
                            OP_CFG_RD: rsp_payload_q <= cfg_q[cmd_payload_inputs_0[1:0]];
                            OP_WR_A: begin
                                a_wr_en_q <= 1'b1;
                                a_index_q <= cmd_payload_inputs_0[ADDR_BITS-1:0];
                                a_wdata_q <= cmd_payload_inputs_1;
                            end
                            OP_WR_B: begin
                                b_wr_en_q <= 1'b1;
                                b_index_q <= cmd_payload_inputs_0[ADDR_BITS-1:0];
                                b_wdata_q <= cmd_payload_inputs_1;
                            end
                            OP_RD_A: begin
                                a_index_q   <= cmd_payload_inputs_0[ADDR_BITS-1:0];
                                rsp_valid_q <= 1'b0;
                                state_q     <= ST_RD_ADDR;
                            end
                            OP_RD_B: begin
                                b_index_q   <= cmd_payload_inputs_0[ADDR_BITS-1:0];
                                rsp_valid_q <= 1'b0;
                                state_q     <= ST_RD_ADDR;
                            end
                            OP_RD_C: begin
                                c_index_q   <= cmd_payload_inputs_0[ADDR_BITS-1:0];
                                c_slice_q   <= cmd_payload_inputs_1;
                                rsp_valid_q <= 1'b0;
                                state_q     <= ST_RD_ADDR;
                            end
                            OP_SET_PTR: begin
                                if (cmd_payload_inputs_0[0]) begin
                                    ptr_b_q <= cmd_payload_inputs_1[ADDR_BITS-1:0];
                                end else begin
                                    ptr_a_q <= cmd_payload_inputs_1[ADDR_BITS-1:0];
                                end
                            end
                            OP_AUTO_A: begin
                                a_wr_en_q     <= 1'b1;
                                a_index_q     <= ptr_a_q;
                                a_wdata_q     <= cmd_payload_inputs_0;
                                ptr_a_q       <= ptr_a_q + ADDR_BITS'(1);
                                rsp_payload_q <= 32'(ptr_a_q);
                            end
                            OP_AUTO_B: begin
                                b_wr_en_q     <= 1'b1;
                                b_index_q     <= ptr_b_q;
                                b_wdata_q     <= cmd_payload_inputs_0;
                                ptr_b_q       <= ptr_b_q + ADDR_BITS'(1);
                                rsp_payload_q <= 32'(ptr_b_q);
                            end
                            OP_START: begin
                                rsp_valid_q <= 1'b0;
                                tpu_start_q <= 1'b1;
                                host_owns_q <= 1'b0;
                                cnt_q       <= '0;
                                state_q     <= ST_RUN;
                            end
                            OP_BUSY: rsp_payload_q <= {31'd0, tpu_busy};
                            OP_LAST: rsp_payload_q <= 32'(last_cnt_q);
                            OP_ERR: begin
                                rsp_payload_q <= {31'd0, err_q};
                                err_q         <= 1'b0;
                            end
                            default: begin
                                rsp_payload_q <= 32'hFFFF_FFFF;
                                err_q         <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_RD_ADDR: state_q <= ST_RD_DATA;
                ST_RD_DATA: begin
                    case (op_q)
                        OP_RD_A: rsp_payload_q <= a_rdata;
                        OP_RD_B: rsp_payload_q <= b_rdata;
                        default: rsp_payload_q <= c_slice_data_s;
                    endcase
                    rsp_valid_q <= 1'b1;
                    state_q     <= ST_RESP;
                end
                ST_RUN: begin
                    // busy is only trusted from the third RUN cycle on
                    cnt_q <= cnt_d;
                    if ((cnt_q >= CNT_BITS'(2)) && !tpu_busy) begin
                        last_cnt_q    <= cnt_d;
                        rsp_payload_q <= 32'(cnt_d);
                        rsp_valid_q   <= 1'b1;
                        host_owns_q   <= 1'b1;
                        state_q       <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready             = (state_q == ST_IDLE);
    assign rsp_valid             = rsp_valid_q;
    assign rsp_payload_outputs_0 = rsp_payload_q;
    assign a_wr_en               = a_wr_en_q;
    assign b_wr_en               = b_wr_en_q;
    assign a_index               = a_index_q;
    assign b_index               = b_index_q;
    assign c_index               = c_index_q;
    assign a_wdata               = a_wdata_q;
    assign b_wdata               = b_wdata_q;
    assign host_owns             = host_owns_q;
    assign tpu_start             = tpu_start_q;
    assign cfg_k                 = cfg_q[CFG_K];
    assign cfg_m                 = cfg_q[CFG_M];
    assign cfg_n                 = cfg_q[CFG_N];
    assign cfg_offset            = cfg_q[CFG_OFFSET];

endmodule
